// File: rtl/pulse_shaper.sv
// pulse_shaper: turns each qualified FIFO pulse into one fixed-width TTL
// pulse followed by a dead time during which further pulses are rejected.
// Optional event counters are built when PULSE_SHAPER_COUNTERS_EN is defined;
// otherwise accepted_cnt/dropped_cnt read 0 and clr_cnt is ignored.
// fsm_state is a debug copy of the internal state (0=IDLE, 1=HIGH, 2=DEAD).
module pulse_shaper #(
   parameter int WIDTH_CYCLES = 10,
   parameter int DEAD_CYCLES  = 20,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   input  logic             in_valid,
   input  logic             clr_cnt,
   output logic             ttl_out,
   output logic             busy,
   output logic [CNT_W-1:0] accepted_cnt,
   output logic [CNT_W-1:0] dropped_cnt,
   output logic [1:0]       fsm_state
);

   localparam int TMAX = (WIDTH_CYCLES > DEAD_CYCLES) ? WIDTH_CYCLES : DEAD_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] W_LOAD = TW'(WIDTH_CYCLES - 1);
   // A zero dead time never loads the timer; the load value is then unused.
   localparam logic [TW-1:0] D_LOAD = (DEAD_CYCLES > 0) ? TW'(DEAD_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      DEAD = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [TW-1:0] tmr;
   logic [TW-1:0] tmr_nxt;
   logic          trig;

   assign trig      = in_valid & pulse_in;
   assign fsm_state = state;

   // Next-state and timer logic; triggers outside IDLE never affect timing.
   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      case (state)
         IDLE: begin
            if (trig) begin
               state_nxt = HIGH;
               tmr_nxt   = W_LOAD;
            end
         end
         HIGH: begin
            if (tmr == '0) begin
               if (DEAD_CYCLES == 0) begin
                  state_nxt = IDLE;
                  tmr_nxt   = '0;
               end else begin
                  state_nxt = DEAD;
                  tmr_nxt   = D_LOAD;
               end
            end else begin
               tmr_nxt = tmr - 1'b1;
            end
         end
         DEAD: begin
            if (tmr == '0) begin
               state_nxt = IDLE;
            end else begin
               tmr_nxt = tmr - 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            tmr_nxt   = '0;
         end
      endcase
   end

   // State register with outputs registered from the next state (glitch-free).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tmr     <= '0;
         ttl_out <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         tmr     <= tmr_nxt;
         ttl_out <= (state_nxt == HIGH);
         busy    <= (state_nxt != IDLE);
      end
   end

`ifdef PULSE_SHAPER_COUNTERS_EN
   logic accept;
   logic drop;

   assign accept = trig & (state == IDLE);
   assign drop   = trig & (state != IDLE);

   // Saturating event counters; a clear wins over a same-edge increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accepted_cnt <= '0;
         dropped_cnt  <= '0;
      end else if (clr_cnt) begin
         accepted_cnt <= '0;
         dropped_cnt  <= '0;
      end else begin
         if (accept && (accepted_cnt != '1)) accepted_cnt <= accepted_cnt + 1'b1;
         if (drop && (dropped_cnt != '1))    dropped_cnt  <= dropped_cnt + 1'b1;
      end
   end
`else
   logic unused_clr;

   assign unused_clr   = clr_cnt;
   assign accepted_cnt = '0;
   assign dropped_cnt  = '0;
`endif

endmodule

// File: tb/tb_pulse_shaper.sv
// tb_pulse_shaper: three pulse_shaper instances (default timing, zero dead
// time, short timing with 4-bit counters) checked every cycle against a
// timing model built from pulse spacing, plus directed counter checks.
module tb_pulse_shaper;

   localparam int W[3]  = '{10, 10, 3};
   localparam int D[3]  = '{20, 0, 2};
   localparam int CW[3] = '{32, 32, 4};
`ifdef PULSE_SHAPER_COUNTERS_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        pin[3];
   logic        vld[3];
   logic        clr[3];
   logic        ttl_o[3];
   logic        busy_o[3];
   logic [31:0] acc_o[3];
   logic [31:0] drop_o[3];
   logic [1:0]  st_o[3];

   logic [31:0] acc0, drop0, acc1, drop1;
   logic [3:0]  acc2, drop2;

   pulse_shaper #(.WIDTH_CYCLES(10), .DEAD_CYCLES(20), .CNT_W(32)) dut0 (
      .clk(clk), .rst_n(rst_n), .pulse_in(pin[0]), .in_valid(vld[0]), .clr_cnt(clr[0]),
      .ttl_out(ttl_o[0]), .busy(busy_o[0]), .accepted_cnt(acc0), .dropped_cnt(drop0),
      .fsm_state(st_o[0]));
   pulse_shaper #(.WIDTH_CYCLES(10), .DEAD_CYCLES(0), .CNT_W(32)) dut1 (
      .clk(clk), .rst_n(rst_n), .pulse_in(pin[1]), .in_valid(vld[1]), .clr_cnt(clr[1]),
      .ttl_out(ttl_o[1]), .busy(busy_o[1]), .accepted_cnt(acc1), .dropped_cnt(drop1),
      .fsm_state(st_o[1]));
   pulse_shaper #(.WIDTH_CYCLES(3), .DEAD_CYCLES(2), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .pulse_in(pin[2]), .in_valid(vld[2]), .clr_cnt(clr[2]),
      .ttl_out(ttl_o[2]), .busy(busy_o[2]), .accepted_cnt(acc2), .dropped_cnt(drop2),
      .fsm_state(st_o[2]));

   assign acc_o[0]  = acc0;
   assign drop_o[0] = drop0;
   assign acc_o[1]  = acc1;
   assign drop_o[1] = drop1;
   assign acc_o[2]  = 32'(acc2);
   assign drop_o[2] = 32'(drop2);

   // scoreboard: {ttl, busy, accepted, dropped}
   logic [65:0] exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   // model: time since last accepted trigger decides everything
   int     edge_n = 0;
   int     last_k[3];
   longint acc_m[3];
   longint drop_m[3];

   function automatic logic [65:0] obs_pack(int i);
      return {ttl_o[i], busy_o[i], acc_o[i], drop_o[i]};
   endfunction

   function automatic logic [65:0] exp_pack(int i);
      logic        t, b;
      logic [31:0] a, d;
      t = (edge_n - last_k[i]) < W[i];
      b = (edge_n - last_k[i]) < (W[i] + D[i]);
      a = CNT_ON ? 32'(acc_m[i]) : 32'd0;
      d = CNT_ON ? 32'(drop_m[i]) : 32'd0;
      return {t, b, a, d};
   endfunction

   task automatic check(string tag, int i, logic [65:0] obs, logic [65:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s inst%0d edge%0d observed=%h expected=%h", tag, i, edge_n, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         last_k[i] = -1000;
         acc_m[i]  = 0;
         drop_m[i] = 0;
      end
   endtask

   // one clock: update model from driven inputs, push, then compare #1 later
   task automatic cycle();
      longint mx;
      @(posedge clk);
      edge_n++;
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            last_k[i] = -1000;
            acc_m[i]  = 0;
            drop_m[i] = 0;
         end else begin
            mx = (64'sd1 <<< CW[i]) - 1;
            if (vld[i] && pin[i]) begin
               if ((edge_n - last_k[i]) >= (W[i] + D[i] + 1)) begin
                  last_k[i] = edge_n;
                  if (acc_m[i] < mx) acc_m[i]++;
               end else if (drop_m[i] < mx) begin
                  drop_m[i]++;
               end
            end
            if (clr[i]) begin
               acc_m[i]  = 0;
               drop_m[i] = 0;
            end
         end
         exp_q.push_back(exp_pack(i));
      end
      #1;
      for (int i = 0; i < 3; i++) check("cycle", i, obs_pack(i), exp_q.pop_front());
   endtask

   // driver: one cycle with a trigger on each instance selected by mask
   task automatic tick(logic [2:0] mask);
      for (int i = 0; i < 3; i++) begin
         pin[i] = mask[i];
         vld[i] = mask[i];
      end
      cycle();
      for (int i = 0; i < 3; i++) begin
         pin[i] = 1'b0;
         vld[i] = 1'b0;
      end
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) tick(3'b000);
   endtask

   task automatic check_cnt(string tag, int i, longint ea, longint ed);
      logic [65:0] expv;
      expv = {ttl_o[i], busy_o[i], CNT_ON ? 32'(ea) : 32'd0, CNT_ON ? 32'(ed) : 32'd0};
      check(tag, i, obs_pack(i), expv);
   endtask

   initial begin
      logic [2:0] m;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pin[i] = 1'b0;
         vld[i] = 1'b0;
         clr[i] = 1'b0;
      end
      model_reset();
      repeat (3) cycle();
      @(negedge clk);
      rst_n = 1'b1;

      // single trigger at edge 5 on default instance
      idle(4);
      tick(3'b001);
      idle(40);
      check_cnt("single", 0, 1, 0);

      // inst0 triggers at 5,8,30,35,36; inst1 (no dead time) at 5,15,16
      for (int r = 1; r <= 50; r++) begin
         m[0] = (r == 5) || (r == 8) || (r == 30) || (r == 35) || (r == 36);
         m[1] = (r == 5) || (r == 15) || (r == 16);
         m[2] = 1'b0;
         tick(m);
      end
      idle(10);
      check_cnt("drop_seq", 0, 3, 3);
      check_cnt("dead0_seq", 1, 2, 1);

      // pulse_in high without in_valid never triggers
      for (int i = 0; i < 3; i++) pin[i] = 1'b1;
      repeat (50) cycle();
      for (int i = 0; i < 3; i++) pin[i] = 1'b0;
      check_cnt("no_valid0", 0, 3, 3);
      check_cnt("no_valid2", 2, 0, 0);

      // 20 well-spaced triggers saturate the 4-bit counter
      for (int n = 0; n < 20; n++) begin
         tick(3'b100);
         idle(6);
      end
      check_cnt("saturate", 2, 15, 0);

      // clear on the same edge as a trigger: clear wins, pulse still emitted
      clr[2] = 1'b1;
      tick(3'b100);
      clr[2] = 1'b0;
      check_cnt("clr_prio", 2, 0, 0);
      idle(8);

      // random triggers and occasional clears
      for (int n = 0; n < 150; n++) begin
         for (int i = 0; i < 3; i++) clr[i] = ($urandom_range(0, 24) == 0);
         m = 3'(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
         tick(m);
      end
      for (int i = 0; i < 3; i++) clr[i] = 1'b0;
      idle(35);

      // asynchronous reset between edges 8 and 9 of a pulse started at edge 5
      idle(4);
      tick(3'b001);
      idle(3);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_cnt("async_rst0", 0, 0, 0);
      check("async_rst_ttl", 0, {ttl_o[0], busy_o[0]}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      tick(3'b111);
      idle(35);
      check_cnt("after_rst", 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
